// File: rtl/dig_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// register select codes, CTRL field positions and the hex segment table.
package dig_pkg;

    // Register select, taken from addr[3:2].
    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_CTRL = 2'd1,
        REG_RSV2 = 2'd2,
        REG_RSV3 = 2'd3
    } reg_sel_e;

    // CTRL field positions.
    localparam int unsigned CTRL_EN_LSB  = 0;
    localparam int unsigned CTRL_DP_LSB  = 8;
    localparam int unsigned CTRL_LZS_BIT = 16;
    localparam int unsigned CTRL_BRT_LSB = 20;
    localparam int unsigned CTRL_BRT_W   = 4;

    // Active-low a..g patterns, bit6 = a ... bit0 = g, indexed by hex value.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,
        7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60,
        7'h31, 7'h42, 7'h30, 7'h38
    };

    function automatic logic [6:0] seg_lookup(input logic [3:0] v);
        return SEG_TABLE[v];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex + DP to active-low 8-bit segment pattern.
// Ports: hex_i nibble, dp_i decimal point request, blank_i forces a..g off,
//        seg_n_o[7] = DP (active low), seg_n_o[6:0] = a..g (active low).
module seg7_decode
    import dig_pkg::*;
(
    input  logic [3:0] hex_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] seg_n_o
);

    always_comb begin
        seg_n_o      = 8'hFF;
        seg_n_o[7]   = ~dp_i;
        seg_n_o[6:0] = blank_i ? 7'h7F : seg_lookup(hex_i);
    end

endmodule

// File: rtl/dig_scan_ctrl.sv
// Multiplexed 7-segment display scan controller with a small register file.
// Ports: clk_from_bg clock, rst_from_bg sync active-low reset,
//        addr_from_bg/we_from_bg/wdata_from_bg register write, rdata_2_bg
//        combinational readback, dig_en_2_soc active-low digit enables,
//        dig_DN_2_soc active-low segments {DP, a..g}; both outputs registered.
module dig_scan_ctrl
    import dig_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int REFRESH_CYCLES = 2000
)
(
    input  logic                  clk_from_bg,
    input  logic                  rst_from_bg,
    input  logic [31:0]           addr_from_bg,
    input  logic                  we_from_bg,
    input  logic [31:0]           wdata_from_bg,
    output logic [31:0]           rdata_2_bg,
    output logic [NUM_DIGITS-1:0] dig_en_2_soc,
    output logic [7:0]            dig_DN_2_soc
);

    localparam int DW     = 4 * NUM_DIGITS;
    localparam int SLOT_W = $clog2(REFRESH_CYCLES);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // One brightness step is 1/16 of a slot.
    localparam int unsigned STEP = REFRESH_CYCLES / 16;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    reg_sel_e sel;

    logic [DW-1:0]         data_q,    data_d;
    logic [NUM_DIGITS-1:0] en_mask_q, en_mask_d;
    logic [NUM_DIGITS-1:0] dp_mask_q, dp_mask_d;
    logic                  lzs_q,     lzs_d;
    logic [3:0]            brt_q,     brt_d;
    logic [SLOT_W-1:0]     slot_q,    slot_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic [NUM_DIGITS-1:0] dig_en_q,  dig_en_d;
    logic [7:0]            dn_q,      dn_d;

    logic                  slot_wrap;
    logic [31:0]           on_limit;
    logic                  lit;
    logic [3:0]            nibble;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic                  blank;
    logic                  dp_req;
    logic [7:0]            seg_n;

    logic unused_ok;

    assign sel = reg_sel_e'(addr_from_bg[3:2]);

    // Only addr[3:2] and the defined CTRL/DATA bits are meaningful.
    assign unused_ok = ^{addr_from_bg, wdata_from_bg};

    // Register writes.
    always_comb begin
        data_d    = data_q;
        en_mask_d = en_mask_q;
        dp_mask_d = dp_mask_q;
        lzs_d     = lzs_q;
        brt_d     = brt_q;
        if (we_from_bg) begin
            unique case (sel)
                REG_DATA: begin
                    data_d = wdata_from_bg[DW-1:0];
                end
                REG_CTRL: begin
                    en_mask_d = wdata_from_bg[CTRL_EN_LSB +: NUM_DIGITS];
                    dp_mask_d = wdata_from_bg[CTRL_DP_LSB +: NUM_DIGITS];
                    lzs_d     = wdata_from_bg[CTRL_LZS_BIT];
                    brt_d     = wdata_from_bg[CTRL_BRT_LSB +: CTRL_BRT_W];
                end
                REG_RSV2, REG_RSV3: begin
                end
            endcase
        end
    end

    // Slot counter and digit index; writes never disturb the scan.
    always_comb begin
        slot_wrap = (slot_q == SLOT_LAST);
        slot_d    = slot_wrap ? '0 : slot_q + 1'b1;
        idx_d     = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Leading-zero detect: upper_zero[i] is set when nibbles i..top are all 0.
    always_comb begin
        logic zacc;
        upper_zero = '0;
        zacc       = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zacc          = zacc && (data_q[4*i +: 4] == 4'd0);
            upper_zero[i] = zacc;
        end
    end

    // Current digit: duty-cycle gate, nibble, blanking and DP request.
    always_comb begin
        on_limit = 32'({1'b0, brt_q} + 5'd1) * STEP;
        lit      = en_mask_q[idx_q] && (32'(slot_q) < on_limit);
        nibble   = data_q[{idx_q, 2'b00} +: 4];
        blank    = lzs_q && (idx_q != '0) && upper_zero[idx_q];
        dp_req   = dp_mask_q[idx_q];
    end

    seg7_decode u_seg7_decode (
        .hex_i   (nibble),
        .dp_i    (dp_req),
        .blank_i (blank),
        .seg_n_o (seg_n)
    );

    // Outputs are computed from the state before the edge, so digit 0 at
    // slot 0 appears on the first edge after reset release.
    always_comb begin
        dig_en_d = '1;
        dn_d     = 8'hFF;
        if (lit) begin
            dig_en_d = ~(NUM_DIGITS'(1) << idx_q);
            dn_d     = seg_n;
        end
    end

    always_ff @(posedge clk_from_bg) begin
        if (!rst_from_bg) begin
            data_q    <= '0;
            en_mask_q <= '1;
            dp_mask_q <= '0;
            lzs_q     <= 1'b0;
            brt_q     <= 4'hF;
            slot_q    <= '0;
            idx_q     <= '0;
            dig_en_q  <= '1;
            dn_q      <= 8'hFF;
        end else begin
            data_q    <= data_d;
            en_mask_q <= en_mask_d;
            dp_mask_q <= dp_mask_d;
            lzs_q     <= lzs_d;
            brt_q     <= brt_d;
            slot_q    <= slot_d;
            idx_q     <= idx_d;
            dig_en_q  <= dig_en_d;
            dn_q      <= dn_d;
        end
    end

    // Combinational readback; unused and reserved bits read zero.
    always_comb begin
        rdata_2_bg = '0;
        unique case (sel)
            REG_DATA: begin
                rdata_2_bg[DW-1:0] = data_q;
            end
            REG_CTRL: begin
                rdata_2_bg[CTRL_EN_LSB +: NUM_DIGITS]  = en_mask_q;
                rdata_2_bg[CTRL_DP_LSB +: NUM_DIGITS]  = dp_mask_q;
                rdata_2_bg[CTRL_LZS_BIT]               = lzs_q;
                rdata_2_bg[CTRL_BRT_LSB +: CTRL_BRT_W] = brt_q;
            end
            REG_RSV2, REG_RSV3: begin
            end
        endcase
    end

    assign dig_en_2_soc = dig_en_q;
    assign dig_DN_2_soc = dn_q;

endmodule

// File: tb/tb_dig_scan_ctrl.sv
// Scoreboard bench for dig_scan_ctrl (NUM_DIGITS=8, REFRESH_CYCLES=32).
// Stimulus pushes the expected outputs per edge; a negedge monitor checks.
module tb_dig_scan_ctrl;

    localparam int ND = 8;
    localparam int RC = 32;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  dig_en;
    logic [7:0]  dn;

    dig_scan_ctrl #(
        .NUM_DIGITS     (ND),
        .REFRESH_CYCLES (RC)
    ) dut (
        .clk_from_bg   (clk),
        .rst_from_bg   (rst_n),
        .addr_from_bg  (addr),
        .we_from_bg    (we),
        .wdata_from_bg (wdata),
        .rdata_2_bg    (rdata),
        .dig_en_2_soc  (dig_en),
        .dig_DN_2_soc  (dn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] en;
        logic [7:0] dn;
        int         n;
    } exp_t;

    exp_t q[$];

    int checks   = 0;
    int failures = 0;

    // Bench view of the programmed configuration.
    logic [7:0] cur_mask;
    int         cur_b;
    logic [7:0] cur_tab [8];
    int         n;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endfunction

    // Monitor: one output presentation per clock, compared at negedge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk($sformatf("en@%0d", e.n), {24'd0, dig_en}, {24'd0, e.en});
            chk($sformatf("dn@%0d", e.n), {24'd0, dn}, {24'd0, e.dn});
        end
    end

    // Advance one edge and queue what that edge must produce.
    task automatic tick();
        exp_t e;
        int   s;
        int   d;
        logic lit;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            n    = 0;
            e.en = 8'hFF;
            e.dn = 8'hFF;
        end else begin
            n++;
            s    = (n - 1) % RC;
            d    = ((n - 1) / RC) % ND;
            lit  = cur_mask[d] && (s < (cur_b + 1) * (RC / 16));
            e.en = lit ? ~(8'd1 << d) : 8'hFF;
            e.dn = lit ? cur_tab[d] : 8'hFF;
        end
        e.n = n;
        q.push_back(e);
    endtask

    task automatic run(input int k);
        repeat (k) tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] dat);
        addr  = a;
        wdata = dat;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] req, input string nm);
        addr = a;
        #1;
        chk(nm, rdata, req);
    endtask

    task automatic set_defaults();
        cur_mask = 8'hFF;
        cur_b    = 15;
        cur_tab  = '{default: 8'h81};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        set_defaults();
        n = 0;

        // Reset held: outputs off, registers at defaults.
        run(3);
        rd(32'h0, 32'h0, "rst_data");
        rd(32'h4, 32'h00F0_00FF, "rst_ctrl");
        rst_n = 1'b1;

        // Full scan FE..7F and wrap back to FE, every digit "0".
        run(RC * ND + RC);

        // All hex glyphs 8..F.
        wr(32'h0, 32'hFEDC_BA98);
        cur_tab = '{8'h80, 8'h84, 8'h88, 8'hE0, 8'hB1, 8'hC2, 8'hB0, 8'hB8};
        rd(32'h0, 32'hFEDC_BA98, "data_rb");
        run(RC * ND);

        // Brightness 3: lit 8 of 32 cycles.
        wr(32'h4, 32'h0030_00FF);
        cur_b = 3;
        rd(32'h4, 32'h0030_00FF, "ctrl_b3");
        run(RC * ND);

        // Leading-zero suppression on 0x105.
        wr(32'h0, 32'h0000_0105);
        cur_tab = '{8'hA4, 8'h81, 8'hCF, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81};
        wr(32'h4, 32'h00F1_00FF);
        cur_b   = 15;
        cur_tab = '{8'hA4, 8'h81, 8'hCF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        rd(32'h4, 32'h00F1_00FF, "ctrl_lzs");
        run(RC * ND);
        wr(32'h4, 32'h00F0_00FF);
        cur_tab = '{8'hA4, 8'h81, 8'hCF, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81};
        run(RC * ND);

        // Mask zero blanks everything; reserved bits read back zero.
        wr(32'h4, 32'hFFFF_0400);
        cur_mask = 8'h00;
        rd(32'h4, 32'h00F1_0400, "ctrl_rsvd");
        run(RC * ND);
        wr(32'h8, 32'hFFFF_FFFF);
        wr(32'hC, 32'hFFFF_FFFF);
        rd(32'h8, 32'h0, "rsv2_rd");
        rd(32'hC, 32'h0, "rsv3_rd");
        tick();
        rd(32'h0, 32'h0000_0105, "data_keep");
        rd(32'h4, 32'h00F1_0400, "ctrl_keep");

        // Only digit 2 enabled, with its DP.
        wr(32'h4, 32'h00F0_0404);
        cur_mask = 8'h04;
        cur_tab  = '{8'hA4, 8'h81, 8'h4F, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81};
        rd(32'h4, 32'h00F0_0404, "ctrl_dp");
        run(RC * ND);

        // Reset mid-slot at digit 5, with a coincident write.
        wr(32'h4, 32'h00F0_00FF);
        cur_mask = 8'hFF;
        cur_tab  = '{8'hA4, 8'h81, 8'hCF, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81};
        for (int k = 0; k < RC * ND; k++) begin
            if (((n / RC) % ND) == 5 && (n % RC) == 10) break;
            tick();
        end
        chk("at_digit5", ((n / RC) % ND), 5);
        rst_n = 1'b0;
        addr  = 32'h0;
        wdata = 32'h1234_5678;
        we    = 1'b1;
        tick();
        we    = 1'b0;
        tick();
        rst_n = 1'b1;
        set_defaults();
        rd(32'h0, 32'h0, "post_rst_data");
        rd(32'h4, 32'h00F0_00FF, "post_rst_ctrl");
        run(RC + 8);

        repeat (3) @(negedge clk);
        chk("sb_drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dig_scan_ctrl.md
DIG_SCAN_CTRL -- requirements
Module: dig_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of scanned digits (legal 1..8).
REQ-002 SHALL have parameter REFRESH_CYCLES, default 2000, clock cycles per digit slot (legal: a multiple of 16, at least 16).
REQ-003 SHALL have port clk_from_bg, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_from_bg, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port addr_from_bg, input, 32, register select; only bits [3:2] are decoded.
REQ-006 SHALL have port we_from_bg, input, 1, write strobe, one write per high cycle.
REQ-007 SHALL have port wdata_from_bg, input, 32, write data.
REQ-008 SHALL have port rdata_2_bg, output, 32, combinational readback of the register selected by addr_from_bg.
REQ-009 SHALL have port dig_en_2_soc, output, NUM_DIGITS, active-low digit enables, registered.
REQ-010 SHALL have port dig_DN_2_soc, output, 8, registered active-low segments: bit7 = DP, bits[6:0] = a..g.

Function
REQ-011 SHALL map registers by addr[3:2]: 0 = DATA (4*NUM_DIGITS bits, nibble i = digit i); 1 = CTRL; 2 and 3 read zero and ignore writes.
REQ-012 SHALL lay out CTRL as: [7:0] digit enable mask; [15:8] DP mask; [16] leading-zero suppress (LZS); [23:20] brightness B; all other bits read 0; mask bits at or above NUM_DIGITS read 0.
REQ-013 SHALL give writes effect at the clock edge where we_from_bg=1; the new value SHALL appear on the outputs one edge later.
REQ-014 SHALL decode the full hex range to bits[6:0]: 0=01 1=4F 2=12 3=06 4=4C 5=24 6=20 7=0F 8=00 9=04 A=08 b=60 C=31 d=42 E=30 F=38.
REQ-015 SHALL run a slot counter 0..REFRESH_CYCLES-1 that wraps; at wrap, the digit index SHALL advance i -> i+1, and NUM_DIGITS-1 -> 0.
REQ-016 SHALL drive exactly one enable low (bit i) when the digit is lit; all others high.
REQ-017 SHALL treat digit i as lit when its enable mask bit=1 and slot counter < (B+1)*(REFRESH_CYCLES/16); B=15 means lit for the whole slot.
REQ-018 SHALL drive an unlit digit as enable bit high and dig_DN_2_soc=8'hFF.
REQ-019 SHALL, with LZS=1, suppress digit i>0 when nibbles i..NUM_DIGITS-1 are all zero: segments a..g off, DP per mask, enable per REQ-017; digit 0 is never suppressed.
REQ-020 SHALL drive DP (bit7) low when DP mask bit i=1 and the digit is lit.
REQ-021 SHALL NOT reset the slot counter or digit index on register writes; a write landing on a slot wrap SHALL use the new value for the new slot.
REQ-022 SHALL give a mask of all zeros all enables high and dig_DN_2_soc=8'hFF, while scanning continues.

Reset
REQ-023 SHALL apply reset while rst_from_bg=0 at a rising edge: DATA=0, enable mask = all NUM_DIGITS ones, DP mask=0, LZS=0, B=15, slot counter=0, index=0.
REQ-024 SHALL hold dig_en_2_soc all ones and dig_DN_2_soc=8'hFF during reset.
REQ-025 SHALL show digit 0 at the first edge after reset release, with no intermediate all-off state.
REQ-026 SHALL make reset asserted mid-slot or mid-write take full effect at that edge; a write coincident with reset is discarded.

Structure
REQ-027 SHALL place in shared package dig_pkg: register offsets, CTRL field positions, and the 16-entry segment table constant.
REQ-028 SHALL implement the hex/DP-to-8-bit decode in one sub-module, seg7_decode (combinational); counters and registers stay in dig_scan_ctrl.

Verification
REQ-029 SHALL cover: reset release with NUM_DIGITS=8, REFRESH_CYCLES=32 -> enables FE, FD, ... 7F, each for 32 cycles, then wrap to FE; DN=01 (digit 0 shows "0").
REQ-030 SHALL cover: write DATA=0xFEDCBA98 -> DN sequence 00,04,08,60,31,42,30,38 over digits 0..7.
REQ-031 SHALL cover: write CTRL with B=3, REFRESH_CYCLES=32 -> each enable low for 8 of 32 cycles, off time DN=FF.
REQ-032 SHALL cover: write DATA=0x00000105 with LZS=1 -> digits 0..2 show 5,0,1; digits 3..7 enable low with DN=7F; with LZS=0 they show 01.
REQ-033 SHALL cover: CTRL enable mask=0x00, DP mask=0x04 -> all enables high; then mask=0x04 -> digit 2 DN bit7=0; readback of CTRL matches the written value with reserved bits zero.
REQ-034 SHALL cover: reset pulsed mid-slot at digit 5 -> outputs FF/FF at that edge, digit 0 on the edge after release, registers back to defaults.
